// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the sequential nibble-based approximate multiplier.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic CMB_ADD = 1'b0;
  localparam logic CMB_OR  = 1'b1;

  typedef enum logic [1:0] {
    APX_EXACT = 2'd0,
    APX_M1    = 2'd1,
    APX_M2    = 2'd2,
    APX_M4    = 2'd3
  } apx_kind_e;

  // Operation configuration latched at accept time
  typedef struct packed {
    logic      comb_mode;
    apx_kind_e apx_kind;
  } cfg_t;

  // Low-bit truncation mask applied to a 4x4 product for each core variant
  function automatic logic [7:0] core_mask(input apx_kind_e k);
    logic [7:0] m;
    m = 8'hFF;
    unique case (k)
      APX_EXACT: m = 8'hFF;
      APX_M1:    m = 8'hFE;
      APX_M2:    m = 8'hFC;
      APX_M4:    m = 8'hF0;
      default:   m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/approx_core4x4.sv
// Combinational 4x4 unsigned multiplier with selectable low-bit truncation.
module approx_core4x4
  import approx_mult_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  apx_kind_e  i_k,
  output logic [7:0] o_p_c
);

  logic [7:0] w_prod;

  assign w_prod = 8'(i_a) * 8'(i_b);
  assign o_p_c  = w_prod & core_mask(i_k);

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential approximate multiplier: folds one nibble-pair partial product per cycle
// through a single shared 4x4 core, combining by add or bitwise OR.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned APX_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               comb_mode,
  input  logic [1:0]         apx_kind,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r
);

  localparam int unsigned D     = WIDTH / 4;
  localparam int unsigned RW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  cfg_t             r_cfg;
  logic [CNT_W-1:0] r_i;
  logic [CNT_W-1:0] r_j;
  logic [RW-1:0]    r_acc;

  logic             w_accept;
  logic             w_last;
  logic [SUM_W-1:0] w_sum;
  logic             w_apx;
  apx_kind_e        w_k;
  logic [WIDTH-1:0] w_a_shf;
  logic [WIDTH-1:0] w_b_shf;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [7:0]       w_pp;
  logic [RW-1:0]    w_pp_sh;
  logic [RW-1:0]    w_acc_nxt;

  assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
  assign w_last   = (r_i == LAST) && (r_j == LAST);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // State and handshake registers; handshakes follow the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Nibble select and weight come straight from the pair counter
  assign w_sum   = SUM_W'(r_i) + SUM_W'(r_j);
  assign w_apx   = (32'(w_sum) < APX_THRESH);
  assign w_k     = w_apx ? r_cfg.apx_kind : APX_EXACT;
  assign w_a_shf = r_a >> {r_i, 2'b00};
  assign w_b_shf = r_b >> {r_j, 2'b00};
  assign w_a_nib = w_a_shf[3:0];
  assign w_b_nib = w_b_shf[3:0];

  approx_core4x4 u_core (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_k   (w_k),
    .o_p_c (w_pp)
  );

  assign w_pp_sh   = RW'(w_pp) << {w_sum, 2'b00};
  assign w_acc_nxt = (r_cfg.comb_mode == CMB_OR) ? (r_acc | w_pp_sh) : (r_acc + w_pp_sh);

  // Operand latch, pair counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cfg <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_cfg <= '{comb_mode: comb_mode, apx_kind: apx_kind_e'(apx_kind)};
      r_i   <= '0;
      r_j   <= '0;
      r_acc <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= w_acc_nxt;
      if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + CNT_W'(1);
      end else begin
        r_j <= r_j + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign r         = r_acc;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed self-checking bench for approx_mult_seq across three parameterisations.
module tb_approx_mult_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid_v;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        comb_mode;
  logic [1:0]  apx_kind;
  logic        out_ready;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [15:0] r0, r1;
  logic [31:0] r2;

  int          dsel;
  logic        m_ir, m_ov;
  logic [31:0] m_r;

  int checks;
  int errors;

  // dut0: WIDTH=8, all pairs exact
  approx_mult_seq #(.WIDTH(8), .APX_THRESH(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .a(a16[7:0]), .b(b16[7:0]), .comb_mode(comb_mode), .apx_kind(apx_kind),
    .out_valid(ov0), .out_ready(out_ready), .r(r0));

  // dut1: WIDTH=8, pair (0,0) approximate
  approx_mult_seq #(.WIDTH(8), .APX_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .a(a16[7:0]), .b(b16[7:0]), .comb_mode(comb_mode), .apx_kind(apx_kind),
    .out_valid(ov1), .out_ready(out_ready), .r(r1));

  // dut2: WIDTH=16
  approx_mult_seq #(.WIDTH(16), .APX_THRESH(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .a(a16), .b(b16), .comb_mode(comb_mode), .apx_kind(apx_kind),
    .out_valid(ov2), .out_ready(out_ready), .r(r2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_ir = ir0;
    m_ov = ov0;
    m_r  = {16'h0, r0};
    case (dsel)
      1: begin m_ir = ir1; m_ov = ov1; m_r = {16'h0, r1}; end
      2: begin m_ir = ir2; m_ov = ov2; m_r = r2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, take the accept edge, then scramble every input
  task automatic start_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic cm, input logic [1:0] k, input string tag);
    dsel = sel;
    @(negedge clk);
    a16 = av; b16 = bv; comb_mode = cm; apx_kind = k;
    in_valid_v = 3'b000;
    in_valid_v[sel] = 1'b1;
    check({tag, "_ready"}, 32'(m_ir), 32'd1);
    @(posedge clk);
    #1;
    in_valid_v = 3'b000;
    a16 = ~av; b16 = ~bv; comb_mode = ~cm; apx_kind = ~k;
  endtask

  task automatic wait_result(input logic [31:0] exp_r, input int exp_lat, input string tag);
    int n;
    n = 1;
    @(negedge clk);
    while (!m_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_r"}, m_r, exp_r);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(m_ov), 32'd0);
    check({tag, "_ir_back"}, 32'(m_ir), 32'd1);
  endtask

  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic cm, input logic [1:0] k,
                        input logic [31:0] exp_r, input int exp_lat, input string tag);
    start_op(sel, av, bv, cm, k, tag);
    wait_result(exp_r, exp_lat, tag);
    finish_op(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; dsel = 0;
    rst = 1'b1; in_valid_v = 3'b000; a16 = '0; b16 = '0;
    comb_mode = 1'b0; apx_kind = 2'd0; out_ready = 1'b0;

    // Reset values on all instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      dsel = s; #1;
      check("rst_ov", 32'(m_ov), 32'd0);
      check("rst_ir", 32'(m_ir), 32'd0);
      check("rst_r", m_r, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      dsel = s; #1;
      check("post_rst_ir", 32'(m_ir), 32'd1);
    end

    // Exact add / OR combine on dut0
    run_op(0, 16'h00FF, 16'h00FF, 1'b0, 2'd0, 32'h0000_FE01, 5, "ff_add");
    run_op(0, 16'h0011, 16'h0011, 1'b1, 2'd0, 32'h0000_0111, 5, "11_or");
    run_op(0, 16'h0011, 16'h0011, 1'b0, 2'd0, 32'h0000_0121, 5, "11_add");

    // Approximate low pair on dut1
    run_op(1, 16'h000F, 16'h000F, 1'b0, 2'd3, 32'h0000_00E0, 5, "0f_k3");
    run_op(1, 16'h000F, 16'h000F, 1'b0, 2'd0, 32'h0000_00E1, 5, "0f_k0");
    run_op(1, 16'h000F, 16'h000F, 1'b1, 2'd1, 32'h0000_00E0, 5, "0f_k1_or");
    run_op(1, 16'h00FF, 16'h00FF, 1'b0, 2'd3, 32'h0000_FE00, 5, "ff_k3");

    // Back-pressure in DONE with stray in_valid pulses
    start_op(0, 16'h00FF, 16'h00FF, 1'b0, 2'd0, "stall");
    wait_result(32'h0000_FE01, 5, "stall");
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = ~i[0];
      a16 = 16'h1234 + 16'(i);
      @(posedge clk);
      @(negedge clk);
      check("stall_ov", 32'(m_ov), 32'd1);
      check("stall_r", m_r, 32'h0000_FE01);
      check("stall_ir", 32'(m_ir), 32'd0);
    end
    in_valid_v = 3'b000;
    finish_op("stall");
    run_op(0, 16'h0012, 16'h0034, 1'b0, 2'd2, 32'h0000_03A8, 5, "after_stall");

    // Reset during the third RUN cycle of dut1
    start_op(1, 16'h00FF, 16'h00FF, 1'b0, 2'd0, "midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ov", 32'(m_ov), 32'd0);
    check("midrst_ir", 32'(m_ir), 32'd0);
    check("midrst_r", m_r, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rel_ir", 32'(m_ir), 32'd1);
    check("midrst_rel_ov", 32'(m_ov), 32'd0);
    run_op(1, 16'h0003, 16'h0005, 1'b0, 2'd0, 32'h0000_000F, 5, "after_rst");

    // WIDTH=16 exact
    run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0, 32'hFFFE_0001, 17, "w16_ff");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_seq.md
APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; multiple of 4, range 4..16.
REQ-002 SHALL have parameter APX_THRESH, default 1: digit-pair (i,j) is approximate when i+j < APX_THRESH, exact otherwise.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands and config valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept.
REQ-007 SHALL have port a, input, WIDTH: multiplicand, unsigned.
REQ-008 SHALL have port b, input, WIDTH: multiplier, unsigned.
REQ-009 SHALL have port comb_mode, input, 1: 0 = exact add combine; 1 = bitwise-OR combine.
REQ-010 SHALL have port apx_kind, input, 2: 4x4 core variant for approximate pairs.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port r, output, 2*WIDTH: product.

Function
REQ-014 SHALL split a and b into D = WIDTH/4 nibbles a_i, b_j (i, j = 0..D-1, 0 = LSB) and form P = D*D partial products.
REQ-015 SHALL compute one partial product per cycle, order i outer, j inner: (0,0), (0,1) ... (D-1,D-1).
REQ-016 SHALL form partial product p_ij = core(a_i, b_j, k), shifted left by 4*(i+j); k = 0 for exact pairs, k = apx_kind for approximate pairs.
REQ-017 SHALL define core: k=0 exact 8-bit product; k=1 product AND 0xFE; k=2 product AND 0xFC; k=3 product AND 0xF0.
REQ-018 SHALL accumulate into a 2*WIDTH register: add modulo 2^(2*WIDTH) when comb_mode=0; bitwise OR when comb_mode=1.
REQ-019 SHALL use FSM IDLE -> RUN -> DONE -> IDLE.
REQ-020 SHALL, in IDLE: in_ready=1; on in_valid accept a, b, comb_mode and apx_kind, clear the accumulator and the pair counter, and go to RUN.
REQ-021 SHALL, in RUN: in_ready=0; fold one pair per cycle; after pair P-1, go to DONE.
REQ-022 SHALL, in DONE: out_valid=1 and r = accumulator, both stable until out_ready=1; on out_ready, go to IDLE.
REQ-023 SHALL assert out_valid exactly P+1 cycles after the accept edge: 5 cycles for WIDTH=8; 17 cycles for WIDTH=16.
REQ-024 SHALL ignore input changes after acceptance; the latched config governs the whole operation.
REQ-025 SHALL NOT accept in DONE (in_ready=0); back-to-back accept is possible in the cycle after DONE exits.
REQ-026 SHALL handle WIDTH=4 (P=1) with the same FSM: one RUN cycle.
REQ-027 SHALL NOT raise overflow: exact mode with k=0 equals a*b exactly; approximate modes never exceed 2*WIDTH bits.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE from any state, including mid-RUN and DONE; the in-flight result is discarded.
REQ-029 SHALL drive these values while in reset: out_valid=0, in_ready=0, r=0.
REQ-030 SHALL raise in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the following in shared package approx_mult_pkg: FSM state enum, comb_mode encodings (CMB_ADD, CMB_OR), apx_kind encodings (APX_EXACT, APX_M1, APX_M2, APX_M4).
REQ-032 SHALL use exactly one sub-module, approx_core4x4 (combinational, a/b/k -> 8-bit product per REQ-017), instantiated once and time-multiplexed.
REQ-033 SHALL implement the nibble select and shift with the pair counter only; no per-pair hardware replication.

Verification
REQ-034 SHALL verify: WIDTH=8, a=0xFF, b=0xFF, comb_mode=0, APX_THRESH=0 -> r=0xFE01, out_valid 5 cycles after accept.
REQ-035 SHALL verify: WIDTH=8, a=0x11, b=0x11, comb_mode=1, APX_THRESH=0 -> r=0x0111; the same operands with comb_mode=0 -> r=0x0121.
REQ-036 SHALL verify: WIDTH=8, APX_THRESH=1, a=0x0F, b=0x0F, apx_kind=3 -> r=0x00E0; with apx_kind=0 -> r=0x00E1.
REQ-037 SHALL verify: out_ready held low for 10 cycles in DONE -> r and out_valid stable; in_valid pulses ignored; accept resumes after the handshake.
REQ-038 SHALL verify: rst asserted in the 3rd RUN cycle -> out_valid=0, in_ready=1 the cycle after release; the next operation 0x03*0x05 gives r=0x000F.
REQ-039 SHALL verify: WIDTH=16, a=0xFFFF, b=0xFFFF, add, exact -> r=0xFFFE0001, out_valid 17 cycles after accept.
